// File: rtl/psl_mmio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psl_mmio_pkg                                                               |
// | Shared MMIO dword map constants and access sequencer states.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package psl_mmio_pkg;

  localparam logic [22:0] c_dw_id     = 23'h000000;
  localparam logic [22:0] c_dw_err    = 23'h000001;
  localparam logic [22:0] c_cfg_desc0 = 23'h000000;
  localparam logic [22:0] c_cfg_desc6 = 23'h000006;

  // Register groups of 16 dwords each: dword index bits [22:4]
  localparam logic [18:0] c_grp_ctrl  = 19'h00001;
  localparam logic [18:0] c_grp_stat  = 19'h00002;
  localparam logic [18:0] c_grp_lock  = 19'h00003;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CAPT = 3'd1,
    ST_EXEC = 3'd2,
    ST_DATA = 3'd3,
    ST_ACK  = 3'd4
  } mmio_state_t;

endpackage
`default_nettype wire

// File: rtl/psl_mmio_regfile_parity.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psl_mmio_regfile_parity                                                    |
// | Parity generator with selectable sense (odd or even).                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module psl_mmio_regfile_parity #(
  parameter int BITS = 64
) (
  input  logic [BITS-1:0] i_data,
  input  logic            i_odd,
  output logic            o_par
);

  // Odd sense: the parity bit makes the total count of ones odd
  assign o_par = (^i_data) ^ i_odd;

endmodule
`default_nettype wire

// File: rtl/psl_mmio_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psl_mmio_regfile                                                           |
// | PSL MMIO/config slave: AFU descriptor, control/status/lock/error regs.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module psl_mmio_regfile
  import psl_mmio_pkg::*;
#(
  parameter int          NUM_CTRL  = 4,
  parameter int          NUM_STAT  = 4,
  parameter int          NUM_LOCK  = 2,
  parameter logic [7:0]  VERSION   = 8'h12,
  parameter bit          CHECK_PAR = 1'b1,
  parameter logic [63:0] AFU_DESC0 = 64'h0000_0001_0000_8010,
  parameter logic [63:0] AFU_DESC6 = 64'h0100_0000_0000_0000
) (
  input  logic                     ha_pclock,
  input  logic                     reset_n,
  input  logic                     ha_mmval,
  input  logic                     ha_mmcfg,
  input  logic                     ha_mmrnw,
  input  logic                     ha_mmdw,
  input  logic [0:23]              ha_mmad,
  input  logic                     ha_mmadpar,
  input  logic [0:63]              ha_mmdata,
  input  logic                     ha_mmdatapar,
  input  logic                     odd_parity,
  output logic                     ah_mmack,
  output logic [0:63]              ah_mmdata,
  output logic                     ah_mmdatapar,
  output logic [0:1]               parity_error,
  output logic [0:64*NUM_CTRL-1]   ctrl_q,
  output logic [0:NUM_CTRL-1]      ctrl_wr,
  input  logic [0:64*NUM_STAT-1]   stat_d,
  output logic [0:NUM_LOCK-1]      lock_q
);

  mmio_state_t r_state;
  mmio_state_t w_next;
  logic        w_accept;
  logic        w_overlap;
  logic        w_exec;

  logic        r_cfg;
  logic        r_rnw;
  logic        r_dw;
  logic [0:23] r_ad;
  logic [0:63] r_wdata;
  logic        r_ad_bad;
  logic        r_dat_bad;

  logic [0:63]         r_ctrl [NUM_CTRL];
  logic [0:NUM_CTRL-1] r_ctrl_wr;
  logic [0:NUM_LOCK-1] r_lock;
  logic [2:0]          r_err;
  logic [2:0]          w_err_nxt;
  logic [0:63]         r_rdata;
  logic                r_ack;
  logic [0:63]         r_mmdata;
  logic                r_mmdatapar;

  logic        w_ad_par;
  logic        w_dat_par;
  logic        w_rd_par;
  logic        w_ad_bad;
  logic        w_dat_bad;

  logic [22:0] w_dw;
  logic [18:0] w_grp;
  logic [3:0]  w_idx;
  logic        w_wr_ok;
  logic [0:63] w_wval;
  logic [0:63] w_wmask;
  logic [0:63] w_id;
  logic [0:63] w_rd_full;
  logic [0:63] w_rd_sel;

  psl_mmio_regfile_parity #(.BITS(24)) u_ad_par (
    .i_data (ha_mmad),
    .i_odd  (odd_parity),
    .o_par  (w_ad_par)
  );

  psl_mmio_regfile_parity #(.BITS(64)) u_dat_par (
    .i_data (ha_mmdata),
    .i_odd  (odd_parity),
    .o_par  (w_dat_par)
  );

  psl_mmio_regfile_parity #(.BITS(64)) u_rd_par (
    .i_data (r_rdata),
    .i_odd  (odd_parity),
    .o_par  (w_rd_par)
  );

  assign w_ad_bad  = CHECK_PAR && (w_ad_par != ha_mmadpar);
  assign w_dat_bad = CHECK_PAR && (w_dat_par != ha_mmdatapar);

  always_ff @(posedge ha_pclock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_overlap = 1'b0;
    w_exec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = ha_mmval;
        if (ha_mmval) begin
          w_next = ST_CAPT;
        end
      end
      ST_CAPT: begin
        w_overlap = ha_mmval;
        w_next    = ST_EXEC;
      end
      ST_EXEC: begin
        w_overlap = ha_mmval;
        w_exec    = 1'b1;
        w_next    = ST_DATA;
      end
      ST_DATA: begin
        w_overlap = ha_mmval;
        w_next    = ST_ACK;
      end
      ST_ACK: begin
        w_overlap = ha_mmval;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ha_pclock) begin
    if (!reset_n) begin
      r_cfg     <= 1'b0;
      r_rnw     <= 1'b0;
      r_dw      <= 1'b0;
      r_ad      <= '0;
      r_wdata   <= '0;
      r_ad_bad  <= 1'b0;
      r_dat_bad <= 1'b0;
    end else if (w_accept) begin
      r_cfg     <= ha_mmcfg;
      r_rnw     <= ha_mmrnw;
      r_dw      <= ha_mmdw;
      r_ad      <= ha_mmad;
      r_wdata   <= ha_mmdata;
      r_ad_bad  <= w_ad_bad;
      r_dat_bad <= !ha_mmrnw && w_dat_bad;
    end
  end

  assign w_dw    = r_ad[0:22];
  assign w_grp   = w_dw[22:4];
  assign w_idx   = w_dw[3:0];
  assign w_wr_ok = !r_rnw && !r_cfg && !r_ad_bad && !r_dat_bad;
  assign w_id    = {VERSION, 4'(NUM_CTRL - 1), 4'(NUM_STAT - 1), 4'(NUM_LOCK - 1), 44'd0};

  // 32-bit writes carry their payload in ha_mmdata[32:63] for either half
  assign w_wval  = r_dw ? r_wdata : {r_wdata[32:63], r_wdata[32:63]};
  assign w_wmask = r_dw    ? {64{1'b1}} :
                   r_ad[23] ? {{32{1'b1}}, 32'd0} : {32'd0, {32{1'b1}}};

  always_comb begin
    w_rd_full = '0;
    if (r_cfg) begin
      if (w_dw == c_cfg_desc0) begin
        w_rd_full = AFU_DESC0;
      end else if (w_dw == c_cfg_desc6) begin
        w_rd_full = AFU_DESC6;
      end
    end else if (w_dw == c_dw_id) begin
      w_rd_full = w_id;
    end else if (w_dw == c_dw_err) begin
      w_rd_full = {61'd0, r_err};
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (w_grp == c_grp_ctrl && w_idx == 4'(i)) begin
          w_rd_full = r_ctrl[i];
        end
      end
      for (int i = 0; i < NUM_STAT; i++) begin
        if (w_grp == c_grp_stat && w_idx == 4'(i)) begin
          w_rd_full = stat_d[64*i +: 64];
        end
      end
      for (int i = 0; i < NUM_LOCK; i++) begin
        if (w_grp == c_grp_lock && w_idx == 4'(i)) begin
          w_rd_full = {63'd0, r_lock[i]};
        end
      end
    end
  end

  assign w_rd_sel = r_dw     ? w_rd_full :
                    r_ad[23] ? {w_rd_full[0:31], w_rd_full[0:31]} :
                               {w_rd_full[32:63], w_rd_full[32:63]};

  // Overlap is recorded even mid-clear so a colliding request is never lost
  always_comb begin
    w_err_nxt = r_err;
    if (w_exec && w_wr_ok && w_dw == c_dw_err) begin
      w_err_nxt = r_err & ~(w_wval[61:63] & w_wmask[61:63]);
    end
    if (w_exec && r_ad_bad) begin
      w_err_nxt[0] = 1'b1;
    end
    if (w_exec && r_dat_bad) begin
      w_err_nxt[1] = 1'b1;
    end
    if (w_overlap) begin
      w_err_nxt[2] = 1'b1;
    end
  end

  always_ff @(posedge ha_pclock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        r_ctrl[i] <= '0;
      end
      r_ctrl_wr <= '0;
      r_lock    <= '0;
      r_err     <= '0;
      r_rdata   <= '0;
    end else begin
      r_ctrl_wr <= '0;
      r_err     <= w_err_nxt;
      if (w_exec) begin
        if (r_rnw) begin
          r_rdata <= w_rd_sel;
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (w_wr_ok && w_grp == c_grp_ctrl && w_idx == 4'(i)) begin
            r_ctrl[i]    <= (r_ctrl[i] & ~w_wmask) | (w_wval & w_wmask);
            r_ctrl_wr[i] <= 1'b1;
          end
        end
        for (int i = 0; i < NUM_LOCK; i++) begin
          if (!r_cfg && w_grp == c_grp_lock && w_idx == 4'(i)) begin
            if (r_rnw) begin
              r_lock[i] <= 1'b1;
            end else if (w_wr_ok) begin
              r_lock[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge ha_pclock) begin
    if (!reset_n) begin
      r_ack       <= 1'b0;
      r_mmdata    <= '0;
      r_mmdatapar <= 1'b0;
    end else begin
      r_ack <= (r_state == ST_DATA);
      if (r_state == ST_DATA && r_rnw) begin
        r_mmdata    <= r_rdata;
        r_mmdatapar <= w_rd_par;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_q
      assign ctrl_q[64*g +: 64] = r_ctrl[g];
    end
  endgenerate

  assign ah_mmack     = r_ack;
  assign ah_mmdata    = r_mmdata;
  assign ah_mmdatapar = r_mmdatapar;
  assign parity_error = {r_err[0], r_err[1]};
  assign ctrl_wr      = r_ctrl_wr;
  assign lock_q       = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_psl_mmio_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_psl_mmio_regfile                                                        |
// | Directed and random accesses compared against a register-map model.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_psl_mmio_regfile;

  localparam int          NC    = 4;
  localparam int          NS    = 4;
  localparam int          NL    = 2;
  localparam logic [63:0] DESC0 = 64'h0000_0001_0000_8010;
  localparam logic [63:0] DESC6 = 64'h0100_0000_0000_0000;

  logic              ha_pclock = 1'b0;
  logic              reset_n;
  logic              ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw;
  logic [0:23]       ha_mmad;
  logic              ha_mmadpar;
  logic [0:63]       ha_mmdata;
  logic              ha_mmdatapar;
  logic              odd_parity;
  logic              ah_mmack;
  logic [0:63]       ah_mmdata;
  logic              ah_mmdatapar;
  logic [0:1]        parity_error;
  logic [0:64*NC-1]  ctrl_q;
  logic [0:NC-1]     ctrl_wr;
  logic [0:64*NS-1]  stat_d;
  logic [0:NL-1]     lock_q;

  logic [63:0] m_ctrl [NC];
  logic [63:0] m_stat [NS];
  logic        m_lock [NL];
  logic        m_ovl, m_dpe, m_ape;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 ha_pclock = ~ha_pclock;

  assign stat_d = {m_stat[0], m_stat[1], m_stat[2], m_stat[3]};

  psl_mmio_regfile #(
    .NUM_CTRL  (NC),
    .NUM_STAT  (NS),
    .NUM_LOCK  (NL),
    .VERSION   (8'h12),
    .CHECK_PAR (1'b1),
    .AFU_DESC0 (DESC0),
    .AFU_DESC6 (DESC6)
  ) dut (
    .ha_pclock    (ha_pclock),
    .reset_n      (reset_n),
    .ha_mmval     (ha_mmval),
    .ha_mmcfg     (ha_mmcfg),
    .ha_mmrnw     (ha_mmrnw),
    .ha_mmdw      (ha_mmdw),
    .ha_mmad      (ha_mmad),
    .ha_mmadpar   (ha_mmadpar),
    .ha_mmdata    (ha_mmdata),
    .ha_mmdatapar (ha_mmdatapar),
    .odd_parity   (odd_parity),
    .ah_mmack     (ah_mmack),
    .ah_mmdata    (ah_mmdata),
    .ah_mmdatapar (ah_mmdatapar),
    .parity_error (parity_error),
    .ctrl_q       (ctrl_q),
    .ctrl_wr      (ctrl_wr),
    .stat_d       (stat_d),
    .lock_q       (lock_q)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NC; i++) m_ctrl[i] = '0;
    for (int i = 0; i < NL; i++) m_lock[i] = 1'b0;
    m_ovl = 1'b0;
    m_dpe = 1'b0;
    m_ape = 1'b0;
  endtask

  // Architectural view of a full 64-bit dword read
  function automatic logic [63:0] m_read(input logic cfg, input logic [22:0] dword);
    int k;
    logic [63:0] v;
    k = int'(dword);
    v = '0;
    if (cfg) begin
      if (k == 0) v = DESC0;
      else if (k == 6) v = DESC6;
    end else if (k == 0) begin
      v = {8'h12, 4'(NC - 1), 4'(NS - 1), 4'(NL - 1), 44'd0};
    end else if (k == 1) begin
      v = {61'd0, m_ovl, m_dpe, m_ape};
    end else if (k >= 16 && k < 16 + NC) begin
      v = m_ctrl[k - 16];
    end else if (k >= 32 && k < 32 + NS) begin
      v = m_stat[k - 32];
    end else if (k >= 48 && k < 48 + NL) begin
      v = {63'd0, m_lock[k - 48]};
    end
    return v;
  endfunction

  task automatic check_state(input string tag);
    logic [0:NL-1] el;
    for (int i = 0; i < NC; i++) chk({tag, "_ctrl_q"}, ctrl_q[64*i +: 64], m_ctrl[i]);
    for (int i = 0; i < NL; i++) el[i] = m_lock[i];
    chk({tag, "_lock_q"}, 64'(lock_q), 64'(el));
    chk({tag, "_parity_error"}, 64'(parity_error), 64'({m_ape, m_dpe}));
  endtask

  task automatic access(input logic cfg, input logic rnw, input logic dw,
                        input logic [22:0] dword, input logic w, input logic [63:0] data,
                        input logic bad_ad, input logic bad_dat, input logic overlap,
                        input string tag);
    logic [63:0]   full, exp_rd, wv, wm;
    logic [0:NC-1] exp_wr;
    logic          ok;
    int            k;
    k      = int'(dword);
    full   = m_read(cfg, dword);
    exp_rd = dw ? full : (w ? {2{full[63:32]}} : {2{full[31:0]}});
    ok     = !rnw && !cfg && !bad_ad && !bad_dat;
    wv     = dw ? data : {2{data[31:0]}};
    wm     = dw ? {64{1'b1}} : (w ? {{32{1'b1}}, 32'd0} : {32'd0, {32{1'b1}}});
    exp_wr = '0;
    if (ok && k >= 16 && k < 16 + NC) begin
      m_ctrl[k - 16] = (m_ctrl[k - 16] & ~wm) | (wv & wm);
      exp_wr[k - 16] = 1'b1;
    end
    if (!cfg && k >= 48 && k < 48 + NL) begin
      if (rnw) m_lock[k - 48] = 1'b1;
      else if (ok) m_lock[k - 48] = 1'b0;
    end
    if (ok && k == 1) begin
      if ((wv[0] & wm[0]) == 1'b1) m_ape = 1'b0;
      if ((wv[1] & wm[1]) == 1'b1) m_dpe = 1'b0;
      if ((wv[2] & wm[2]) == 1'b1) m_ovl = 1'b0;
    end
    if (bad_ad) m_ape = 1'b1;
    if (bad_dat && !rnw) m_dpe = 1'b1;
    if (overlap) m_ovl = 1'b1;

    @(negedge ha_pclock);
    ha_mmval     = 1'b1;
    ha_mmcfg     = cfg;
    ha_mmrnw     = rnw;
    ha_mmdw      = dw;
    ha_mmad      = {dword, w};
    ha_mmadpar   = (^{dword, w}) ^ odd_parity ^ bad_ad;
    ha_mmdata    = data;
    ha_mmdatapar = (^data) ^ odd_parity ^ bad_dat;
    @(negedge ha_pclock);
    if (!overlap) ha_mmval = 1'b0;
    chk({tag, "_ack_t1"}, 64'(ah_mmack), 64'd0);
    @(negedge ha_pclock);
    ha_mmval = 1'b0;
    chk({tag, "_ack_t2"}, 64'(ah_mmack), 64'd0);
    @(negedge ha_pclock);
    chk({tag, "_ctrl_wr_t3"}, 64'(ctrl_wr), 64'(exp_wr));
    chk({tag, "_ack_t3"}, 64'(ah_mmack), 64'd0);
    @(negedge ha_pclock);
    chk({tag, "_ack_t4"}, 64'(ah_mmack), 64'd1);
    if (rnw) begin
      chk({tag, "_rdata"}, ah_mmdata, exp_rd);
      chk({tag, "_rpar"}, 64'(ah_mmdatapar), 64'((^exp_rd) ^ odd_parity));
    end
    check_state(tag);
    if (overlap) begin
      repeat (2) begin
        @(negedge ha_pclock);
        chk({tag, "_no_second_ack"}, 64'(ah_mmack), 64'd0);
      end
    end
  endtask

  initial begin
    logic [22:0] dsel;
    logic        rcfg, rrnw, rdw, rw, rbad;
    int          sel;

    reset_n      = 1'b0;
    ha_mmval     = 1'b0;
    ha_mmcfg     = 1'b0;
    ha_mmrnw     = 1'b0;
    ha_mmdw      = 1'b0;
    ha_mmad      = '0;
    ha_mmadpar   = 1'b0;
    ha_mmdata    = '0;
    ha_mmdatapar = 1'b0;
    odd_parity   = 1'b1;
    for (int i = 0; i < NS; i++) m_stat[i] = {$urandom, $urandom};
    m_reset();
    repeat (3) @(negedge ha_pclock);
    chk("rst_ack", 64'(ah_mmack), 64'd0);
    chk("rst_rdata", ah_mmdata, 64'd0);
    chk("rst_rpar", 64'(ah_mmdatapar), 64'd0);
    chk("rst_ctrl_wr", 64'(ctrl_wr), 64'd0);
    check_state("rst");
    reset_n = 1'b1;

    access(0, 0, 1, 23'h12, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, "wr64_ctrl2");
    access(0, 1, 1, 23'h12, 0, 64'd0, 0, 0, 0, "rd64_ctrl2");
    odd_parity = 1'b0;
    access(0, 1, 1, 23'h12, 0, 64'd0, 0, 0, 0, "rd64_ctrl2_even");

    access(0, 0, 1, 23'h10, 0, 64'h1111_2222_3333_4444, 0, 0, 0, "wr64_ctrl0");
    access(0, 0, 0, 23'h10, 1, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, "wr32_hi_ctrl0");
    access(0, 1, 0, 23'h10, 0, 64'd0, 0, 0, 0, "rd32_lo_ctrl0");
    access(0, 1, 0, 23'h10, 1, 64'd0, 0, 0, 0, "rd32_hi_ctrl0");

    access(0, 1, 1, 23'h31, 0, 64'd0, 0, 0, 0, "lock1_rd_a");
    access(0, 1, 1, 23'h31, 0, 64'd0, 0, 0, 0, "lock1_rd_b");
    access(0, 0, 1, 23'h31, 0, 64'd0, 0, 0, 0, "lock1_wr");

    access(0, 0, 1, 23'h11, 0, 64'hCAFE_F00D_0000_0001, 0, 1, 0, "badpar_wr");
    access(0, 1, 1, 23'h01, 0, 64'd0, 0, 0, 0, "err_rd_dpe");
    access(0, 0, 1, 23'h01, 0, 64'h2, 0, 0, 0, "err_w1c");
    access(0, 0, 1, 23'h13, 0, 64'h5, 1, 0, 0, "badad_wr");
    access(0, 0, 1, 23'h01, 0, 64'h1, 0, 0, 0, "err_w1c_ape");

    access(1, 1, 1, 23'h06, 0, 64'd0, 0, 0, 0, "cfg_desc6");
    access(1, 1, 1, 23'h00, 0, 64'd0, 0, 0, 0, "cfg_desc0");
    access(1, 0, 1, 23'h10, 0, 64'hFFFF, 0, 0, 0, "cfg_wr_noeffect");
    m_stat[1] = 64'h55;
    access(0, 1, 1, 23'h21, 0, 64'd0, 0, 0, 0, "stat1");
    access(0, 1, 1, 23'h00, 0, 64'd0, 0, 0, 0, "id");
    access(0, 1, 1, 23'h14, 0, 64'd0, 0, 0, 0, "unmapped_ctrl4");

    access(0, 0, 1, 23'h13, 0, 64'h0BAD_0BAD_0BAD_0BAD, 0, 0, 1, "overlap_wr");
    access(0, 1, 1, 23'h01, 0, 64'd0, 0, 0, 0, "err_rd_ovl");
    access(0, 0, 0, 23'h01, 0, 64'h4, 0, 0, 0, "err_w1c_ovl32");

    // Reset lands on the execute cycle of a write: no ack, everything cleared
    @(negedge ha_pclock);
    ha_mmval  = 1'b1;
    ha_mmcfg  = 1'b0;
    ha_mmrnw  = 1'b0;
    ha_mmdw   = 1'b1;
    ha_mmad   = {23'h12, 1'b0};
    ha_mmadpar = (^ha_mmad) ^ odd_parity;
    ha_mmdata = 64'h7777_8888_9999_AAAA;
    ha_mmdatapar = (^ha_mmdata) ^ odd_parity;
    @(negedge ha_pclock);
    ha_mmval = 1'b0;
    @(negedge ha_pclock);
    reset_n = 1'b0;
    @(negedge ha_pclock);
    reset_n = 1'b1;
    m_reset();
    repeat (4) begin
      chk("rst_mid_no_ack", 64'(ah_mmack), 64'd0);
      @(negedge ha_pclock);
    end
    check_state("rst_mid");

    for (int n = 0; n < 64; n++) begin
      for (int i = 0; i < NS; i++) m_stat[i] = {$urandom, $urandom};
      odd_parity = 1'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 15));
      rcfg = ($urandom_range(0, 9) == 0);
      rrnw = 1'($urandom_range(0, 1));
      rdw  = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      rbad = ($urandom_range(0, 15) == 0);
      if (sel == 0) dsel = 23'h0;
      else if (sel == 1) dsel = 23'h1;
      else if (sel < 6) dsel = 23'(16 + $urandom_range(0, 5));
      else if (sel < 8) dsel = 23'(32 + $urandom_range(0, 5));
      else if (sel < 10) dsel = 23'(48 + $urandom_range(0, 3));
      else if (sel == 10) dsel = 23'($urandom);
      else dsel = 23'(16 + $urandom_range(0, 3));
      if (rcfg && $urandom_range(0, 1) == 1) dsel = 23'h6;
      access(rcfg, rrnw, rdw, dsel, rw, {$urandom, $urandom},
             rbad && sel[0], rbad && !sel[0], 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
